// File: rtl/bus_arbiter_bcast.sv
// Bus generator/arbiter: pops one packet from a pending device FIFO, then pushes it
// to the addressed device or broadcasts it to all others; bad/self IDs are counted as drops.
module bus_arbiter_bcast #(
  parameter int unsigned PCKG_SZ  = 16,
  parameter int unsigned DRVRS    = 8,
  parameter logic [7:0]  BCAST    = 8'hFF,
  parameter int unsigned ARB_MODE = 0,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DRVRS-1:0]         pndng,
  input  logic [DRVRS*PCKG_SZ-1:0] D_pop,
  output logic [DRVRS-1:0]         pop,
  input  logic [DRVRS-1:0]         full,
  output logic [DRVRS-1:0]         push,
  output logic [PCKG_SZ-1:0]       D_push,
  output logic                     busy,
  output logic [CNT_W-1:0]         drop_cnt
);

  localparam int unsigned IW = $clog2(DRVRS);

  typedef enum logic {IDLE, HOLD} state_e;

  state_e             state_q;
  logic [IW-1:0]      ptr_q;
  logic [IW-1:0]      src_q;
  logic [PCKG_SZ-1:0] pkt_q;
  logic [PCKG_SZ-1:0] last_q;
  logic [CNT_W-1:0]   drop_q;

  logic [IW-1:0]      grant;
  logic               gnt_vld;
  logic [7:0]         dest;
  logic [DRVRS-1:0]   tmask;
  logic               stall;

  // Fixed priority scans 0..DRVRS-1; round-robin scans ptr+1.. wrapping.
  always_comb begin : arb
    int unsigned idx;
    idx     = 0;
    grant   = '0;
    gnt_vld = 1'b0;
    for (int unsigned k = 1; k <= DRVRS; k++) begin
      if (ARB_MODE == 1) idx = k - 1;
      else               idx = (32'(ptr_q) + k) % DRVRS;
      if (!gnt_vld && pndng[IW'(idx)]) begin
        grant   = IW'(idx);
        gnt_vld = 1'b1;
      end
    end
  end

  always_comb begin
    dest  = pkt_q[PCKG_SZ-1 -: 8];
    tmask = '0;
    if (dest == BCAST) begin
      tmask        = '1;
      tmask[src_q] = 1'b0;
    end else if (32'(dest) < DRVRS && 32'(dest) != 32'(src_q)) begin
      tmask[IW'(dest)] = 1'b1;
    end
  end

  assign stall = |(tmask & full);

  // Strobes decode from the registered state so pop and push land in the
  // same cycle the decision is made; reset gates them off immediately.
  always_comb begin
    pop  = '0;
    push = '0;
    if (reset && state_q == IDLE && gnt_vld) pop[grant] = 1'b1;
    if (reset && state_q == HOLD && !stall)  push = tmask;
  end

  assign D_push   = (|push) ? pkt_q : last_q;
  assign busy     = (state_q == HOLD);
  assign drop_cnt = drop_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      ptr_q   <= IW'(DRVRS - 1);
      src_q   <= '0;
      pkt_q   <= '0;
      last_q  <= '0;
      drop_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (gnt_vld) begin
            pkt_q   <= D_pop[32'(grant)*PCKG_SZ +: PCKG_SZ];
            src_q   <= grant;
            if (ARB_MODE == 0) ptr_q <= grant;
            state_q <= HOLD;
          end
        end
        HOLD: begin
          if (tmask == '0) begin
            if (drop_q != '1) drop_q <= drop_q + CNT_W'(1);
            state_q <= IDLE;
          end else if (!stall) begin
            last_q  <= pkt_q;
            state_q <= IDLE;
          end
        end
      endcase
    end
  end

endmodule
